dmem_port_arbiter: RTL

Shares the single unified memory port between the instruction-fetch requester and the data-memory (load/store) requester. It sequences each access as a req/ack transaction and forwards the 3-bit `dm_ctrl` size/sign code unchanged on data accesses. It returns read data to the winning requester and provides the stall signals the pipeline uses while either side waits. It sits between the IF/MEM stages and the memory model or bus bridge.

---
 rtl/dmem_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one unified memory port between the instruction-fetch requester and
// the load/store requester. Each access runs as a req/ack transaction on the
// port. The arbiter returns read data to the winner and produces the pipeline
// stall signals.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr                fetch request (held until if_valid)
//   if_rdata/if_valid             fetched word + one-cycle completion pulse
//   dm_req/dm_we/dm_ctrl/dm_addr/dm_wdata
//                                 data request (held until dm_done)
//   dm_rdata/dm_done              load data + one-cycle completion pulse
//   bus_err                       pulses with a completion that timed out
//   stall_if/stall_mem            combinational requester stalls
//   mem_req/mem_we/mem_ctrl/mem_addr/mem_wdata
//                                 registered port outputs
//   mem_rdata/mem_ack             port read data + one-cycle completion
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | sample requests, grant one side
// IF_WAIT | fetch on the port, waiting for mem_ack or timeout
// DM_WAIT | data access on the port, waiting for mem_ack or timeout
// DONE    | completion pulse, update round-robin, no grant this cycle

module dmem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [2:0]        dm_ctrl,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              bus_err,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [2:0]        mem_ctrl,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_WAIT = 2'd1,
      DM_WAIT = 2'd2,
      DONE    = 2'd3
   } state_t;

   // The counter holds the number of ack-less WAIT cycles already elapsed, so
   // the last permitted cycle is the one where it equals TIMEOUT-1.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic        last_dm;
   logic        served_dm;
   logic [15:0] wait_cnt;
   logic        grant_dm;

   // On a tie, the side that was not served last wins.
   assign grant_dm = dm_req & (~if_req | ~last_dm);

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last_dm   <= 1'b0;
         served_dm <= 1'b0;
         wait_cnt  <= 16'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_ctrl  <= 3'b000;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_done   <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_done  <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_dm) begin
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_ctrl  <= dm_ctrl;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  wait_cnt  <= 16'd0;
                  served_dm <= 1'b1;
                  state     <= DM_WAIT;
               end else if (if_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_ctrl  <= 3'b010;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  wait_cnt  <= 16'd0;
                  served_dm <= 1'b0;
                  state     <= IF_WAIT;
               end
            end
            IF_WAIT, DM_WAIT: begin
               // An ack in the final permitted cycle still counts as success.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (served_dm) begin
                     dm_rdata <= mem_rdata;
                     dm_done  <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_valid <= 1'b1;
                  end
                  state <= DONE;
               end else if (wait_cnt == WAIT_LAST) begin
                  mem_req <= 1'b0;
                  bus_err <= 1'b1;
                  if (served_dm) begin
                     dm_rdata <= '0;
                     dm_done  <= 1'b1;
                  end else begin
                     if_rdata <= '0;
                     if_valid <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            DONE: begin
               last_dm <= served_dm;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
